disp_fetch_ctrl: RTL and testbench
==================================

Name: disp_fetch_ctrl

Overview:
- Fetch sequencer for the display frame buffer path, clocked by ACLK.
- On each frame start it flushes the display FIFO, then issues AXI4 read-address bursts that walk the frame from DISPADDR.
- Issue is throttled by FIFO space and an outstanding-burst credit; returning read beats are steered into the FIFO write port.
- Sits between the AXI master read channel and the display FIFO/pixel-output block.

Parameters:
- ADDR_W, 32, AXI address width.
- BURST_LEN, 16, beats per burst (64-bit beats); ARLEN = BURST_LEN-1.
- FRAME_BEATS, 307200, 64-bit beats per frame (1280x480 px at 2 px/beat); must be a multiple of BURST_LEN.
- MAX_OUTST, 2, maximum outstanding read bursts (1..4).
- FLUSH_CYC, 8, FIFORST hold length in cycles.

Ports:
- ACLK  in  1  system clock
- ARST  in  1  reset, synchronous to ACLK, active-high
- DISPON  in  1  display enable
- DISPADDR  in  ADDR_W  frame base byte address, BURST_LEN*8 aligned; sampled at frame start
- VSTART  in  1  one-cycle frame-start pulse, already in ACLK domain
- BUF_WREADY  in  1  FIFO can accept MAX_OUTST*BURST_LEN more words
- FIFORST  out  1  FIFO reset
- FIFOWR  out  1  FIFO write strobe
- ARADDR  out  ADDR_W  burst address
- ARLEN  out  8  constant BURST_LEN-1
- ARVALID  out  1
- ARREADY  in  1
- RVALID  in  1
- RLAST  in  1
- RREADY  out  1
- BUSY  out  1  state != IDLE
- FRAME_DONE  out  1  one-cycle pulse when the last burst of a frame completes

Behaviour:
- Reset (ARST=1 at a rising ACLK edge): state IDLE; all counters 0; all outputs 0 except ARLEN (constant).
- RREADY=1 in every state after reset. No backpressure is needed because issue is gated by BUF_WREADY.
- FIFOWR = RVALID & RREADY & (state==RUN), combinational. Read data itself bypasses this block.
- States:
  - IDLE: VSTART & DISPON -> FLUSH. On that edge: addr<=DISPADDR, remaining<=FRAME_BEATS/BURST_LEN, flush_cnt<=FLUSH_CYC-1.
  - FLUSH: FIFORST=1, flush_cnt decrements each cycle. flush_cnt==0 -> RUN. FIFORST is registered, so it is high for exactly FLUSH_CYC cycles.
  - RUN:
    - ARVALID asserts when remaining!=0 & outst<MAX_OUTST & BUF_WREADY & DISPON.
    - Once asserted, ARVALID and ARADDR stay stable until ARREADY (AXI rule), even if BUF_WREADY or DISPON drop.
    - On the AR handshake: addr+=BURST_LEN*8 (mod 2^ADDR_W, no wrap check), remaining--, outst++.
    - On RVALID&RREADY&RLAST: outst--. AR handshake and RLAST in the same cycle leave outst unchanged.
    - remaining==0 & outst==0 -> IDLE with FRAME_DONE=1 for that one cycle.
    - DISPON=0 with no ARVALID pending -> ABORT.
  - ABORT: no new AR issued; R beats accepted and discarded (FIFOWR=0). outst==0 -> IDLE, with no FRAME_DONE.
- ARVALID can be issued back-to-back; there is no bubble after a handshake if all conditions still hold.
- VSTART outside IDLE is ignored; the frame in progress continues.
- VSTART in IDLE with DISPON=0 is ignored.
- ARST mid-burst returns to IDLE immediately. AXI consistency after that is the interconnect's concern, since interconnect reset is shared.
- Counter widths:
  - remaining: clog2(FRAME_BEATS/BURST_LEN+1)
  - outst: clog2(MAX_OUTST+1)
  - flush_cnt: clog2(FLUSH_CYC)

Optional Feature:
- Macro DISP_FETCH_LATE_EN.
- When defined:
  - Adds output LATE_CNT (16 bits).
  - LATE_CNT increments, saturating at 16'hFFFF, on each VSTART&DISPON that arrives while state!=IDLE.
  - LATE_CNT clears on ARST.
- When undefined: the port is absent and the logic is removed; VSTART outside IDLE is silently ignored as above.

Decomposition:
- disp_pkg holds:
  - the state enum (IDLE, FLUSH, RUN, ABORT)
  - the beat width constant 8 bytes
  - a helper for the ARLEN encoding
- Sub-module disp_fetch_credit: outst up/down counter taking inc (AR handshake) and dec (RLAST handshake), outputting avail = outst<MAX_OUTST and zero = outst==0. Everything else stays flat in disp_fetch_ctrl.

Test Plan:
- Sim params BURST_LEN=16, FRAME_BEATS=64, MAX_OUTST=2, FLUSH_CYC=8.
- Full frame: DISPADDR=32'h1000_0000, VSTART, slave always ready -> FIFORST high for exactly 8 cycles; ARADDR sequence 1000_0000/0080/0100/0180; ARLEN=15; 64 FIFOWR pulses; one FRAME_DONE; BUSY low afterwards.
- Credit limit: R channel stalled -> exactly 2 AR handshakes, then ARVALID low. Release one RLAST -> third AR issues.
- Throttle and stability: BUF_WREADY=0 -> no ARVALID. ARREADY held low for 5 cycles while ARVALID=1 and BUF_WREADY toggles -> ARVALID and ARADDR stay stable.
- Abort: DISPON drops after 2nd AR -> ABORT; R beats accepted with FIFOWR=0; IDLE after last RLAST; no FRAME_DONE.
- Late VSTART: pulse VSTART mid-RUN -> addresses unaffected; with DISP_FETCH_LATE_EN, LATE_CNT=1.
- Reset mid-burst: ARST asserted during RUN -> next cycle ARVALID=0, FIFORST=0, BUSY=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display fetch sequencer.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRun,
        StAbort
    } disp_state_e;

    localparam int unsigned BEAT_BYTES = 8;

    function automatic logic [7:0] arlen_enc(input int unsigned burst_len);
        return 8'(burst_len - 1);
    endfunction

endpackage

// File: rtl/disp_fetch_credit.sv
// Outstanding read-burst credit counter: counts AR handshakes up and RLAST beats down.
module disp_fetch_credit #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_avail,
    output logic o_zero
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0] r_outst;
    logic             w_dec;

    // A stray RLAST with nothing outstanding must not wrap the counter.
    assign w_dec = i_dec && (r_outst != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outst <= '0;
        end else if (i_inc && !w_dec) begin
            r_outst <= r_outst + CNT_W'(1);
        end else if (!i_inc && w_dec) begin
            r_outst <= r_outst - CNT_W'(1);
        end
    end

    assign o_avail = (r_outst < CNT_W'(MAX_OUTST));
    assign o_zero  = (r_outst == '0);

endmodule

// File: rtl/disp_fetch_ctrl.sv
// Display frame fetch sequencer: flush FIFO, then walk the frame with AXI read bursts.
// Optional late-VSTART counter output LATE_CNT when DISP_FETCH_LATE_EN is defined.
module disp_fetch_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_BEATS = 307200,
    parameter int unsigned MAX_OUTST   = 2,
    parameter int unsigned FLUSH_CYC   = 8
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              DISPON,
    input  logic [ADDR_W-1:0] DISPADDR,
    input  logic              VSTART,
    input  logic              BUF_WREADY,
    output logic              FIFORST,
    output logic              FIFOWR,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic              RVALID,
    input  logic              RLAST,
    output logic              RREADY,
    output logic              BUSY,
    output logic              FRAME_DONE
`ifdef DISP_FETCH_LATE_EN
    ,
    output logic [15:0]       LATE_CNT
`endif
);

    localparam int unsigned BURSTS = FRAME_BEATS / BURST_LEN;
    localparam int unsigned REM_W  = $clog2(BURSTS + 1);
    localparam int unsigned FL_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * BEAT_BYTES);

    disp_state_e       r_state, w_state_d;
    logic [ADDR_W-1:0] r_addr;
    logic [REM_W-1:0]  r_remaining;
    logic [FL_W-1:0]   r_flush_cnt;
    logic              r_ar_pend;
    logic              r_rready;
    logic              r_fiforst;
    logic              r_frame_done;

    logic w_frame_start;
    logic w_done;
    logic w_arvalid;
    logic w_ar_hs;
    logic w_r_last;
    logic w_avail;
    logic w_zero;

    disp_fetch_credit #(
        .MAX_OUTST (MAX_OUTST)
    ) u_credit (
        .i_clk   (ACLK),
        .i_rst   (ARST),
        .i_inc   (w_ar_hs),
        .i_dec   (w_r_last),
        .o_avail (w_avail),
        .o_zero  (w_zero)
    );

    // A request already on the bus is held regardless of throttle inputs.
    assign w_arvalid = r_ar_pend ||
                       ((r_state == StRun) && (r_remaining != '0) && w_avail &&
                        BUF_WREADY && DISPON);
    assign w_ar_hs   = w_arvalid && ARREADY;
    assign w_r_last  = RVALID && r_rready && RLAST;

    always_comb begin
        w_state_d     = r_state;
        w_frame_start = 1'b0;
        w_done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (VSTART && DISPON) begin
                    w_state_d     = StFlush;
                    w_frame_start = 1'b1;
                end
            end
            StFlush: begin
                if (r_flush_cnt == '0) w_state_d = StRun;
            end
            StRun: begin
                if ((r_remaining == '0) && w_zero) begin
                    w_state_d = StIdle;
                    w_done    = 1'b1;
                end else if (!DISPON && !r_ar_pend) begin
                    w_state_d = StAbort;
                end
            end
            StAbort: begin
                if (w_zero) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_flush_cnt  <= '0;
            r_ar_pend    <= 1'b0;
            r_rready     <= 1'b0;
            r_fiforst    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ar_pend    <= w_arvalid && !ARREADY;
            r_rready     <= 1'b1;
            r_fiforst    <= (w_state_d == StFlush);
            r_frame_done <= w_done;
            if (w_frame_start) begin
                r_addr      <= DISPADDR;
                r_remaining <= REM_W'(BURSTS);
                r_flush_cnt <= FL_W'(FLUSH_CYC - 1);
            end else begin
                if ((r_state == StFlush) && (r_flush_cnt != '0)) begin
                    r_flush_cnt <= r_flush_cnt - FL_W'(1);
                end
                if (w_ar_hs) begin
                    r_addr      <= r_addr + ADDR_STEP;
                    r_remaining <= r_remaining - REM_W'(1);
                end
            end
        end
    end

`ifdef DISP_FETCH_LATE_EN
    logic [15:0] r_late_cnt;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_late_cnt <= '0;
        end else if (VSTART && DISPON && (r_state != StIdle) && (r_late_cnt != 16'hFFFF)) begin
            r_late_cnt <= r_late_cnt + 16'd1;
        end
    end

    assign LATE_CNT = r_late_cnt;
`endif

    assign FIFORST    = r_fiforst;
    assign FIFOWR     = RVALID && r_rready && (r_state == StRun);
    assign ARADDR     = r_addr;
    assign ARLEN      = arlen_enc(BURST_LEN);
    assign ARVALID    = w_arvalid;
    assign RREADY     = r_rready;
    assign BUSY       = (r_state != StIdle);
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_disp_fetch_ctrl.sv
// Self-checking bench for disp_fetch_ctrl: directed scenarios plus random traffic vs a frame model.
module tb_disp_fetch_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned BL = 16;
    localparam int unsigned FB = 64;
    localparam int unsigned MO = 2;
    localparam int unsigned FC = 8;
    localparam int unsigned BIG = 32'h4000_0000;

    logic          ACLK = 1'b0;
    logic          ARST = 1'b1;
    logic          DISPON = 1'b0;
    logic [AW-1:0] DISPADDR = '0;
    logic          VSTART = 1'b0;
    logic          BUF_WREADY = 1'b1;
    logic          FIFORST, FIFOWR, ARVALID, RREADY, BUSY, FRAME_DONE;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic          ARREADY = 1'b0;
    logic          RVALID = 1'b0;
    logic          RLAST = 1'b0;
`ifdef DISP_FETCH_LATE_EN
    logic [15:0]   LATE_CNT;
`endif

    always #5 ACLK = ~ACLK;

    disp_fetch_ctrl #(
        .ADDR_W      (AW),
        .BURST_LEN   (BL),
        .FRAME_BEATS (FB),
        .MAX_OUTST   (MO),
        .FLUSH_CYC   (FC)
    ) dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .DISPON     (DISPON),
        .DISPADDR   (DISPADDR),
        .VSTART     (VSTART),
        .BUF_WREADY (BUF_WREADY),
        .FIFORST    (FIFORST),
        .FIFOWR     (FIFOWR),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RVALID     (RVALID),
        .RLAST      (RLAST),
        .RREADY     (RREADY),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
`ifdef DISP_FETCH_LATE_EN
        ,
        .LATE_CNT   (LATE_CNT)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: phase 0 idle, 1 flushing, 2 fetching, 3 draining after abort.
    int          m_phase = 0;
    int          m_flush_left = 0;
    int          m_left = 0;
    int          m_inflight = 0;
    bit          m_held = 0;
    bit          m_done = 0;
    bit          m_rready = 0;
    logic [31:0] m_addr = '0;
    int          m_late = 0;

    // Read slave: one entry per accepted burst, holding beats still to return.
    int q[$];
    int ar_pct = 100;
    int r_pct = 100;
    int r_budget = BIG;

    int          obs_hs, obs_fiforst, obs_fifowr, obs_done;
    logic [31:0] obs_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_hs = 0;
        obs_fiforst = 0;
        obs_fifowr = 0;
        obs_done = 0;
        obs_addr.delete();
    endtask

    task automatic cycle();
        bit exp_arvalid, exp_fifowr, hs, acc, last, done_n;
        int pre_phase;
        @(negedge ACLK);
        ARREADY = ($urandom_range(99) < ar_pct);
        if (q.size() > 0 && r_budget > 0 && $urandom_range(99) < r_pct) begin
            RVALID = 1'b1;
            RLAST  = (q[0] == 1);
        end else begin
            RVALID = 1'b0;
            RLAST  = 1'b0;
        end
        #1;
        exp_arvalid = m_held || (m_phase == 2 && m_left > 0 && m_inflight < MO &&
                                 BUF_WREADY && DISPON);
        exp_fifowr  = RVALID && m_rready && (m_phase == 2);
        chk("arvalid", 32'(ARVALID), 32'(exp_arvalid));
        chk("araddr", ARADDR, m_addr);
        chk("fiforst", 32'(FIFORST), 32'(m_phase == 1));
        chk("fifowr", 32'(FIFOWR), 32'(exp_fifowr));
        chk("rready", 32'(RREADY), 32'(m_rready));
        chk("busy", 32'(BUSY), 32'(m_phase != 0));
        chk("frame_done", 32'(FRAME_DONE), 32'(m_done));
        chk("arlen", 32'(ARLEN), 32'(BL - 1));
`ifdef DISP_FETCH_LATE_EN
        chk("late_cnt", 32'(LATE_CNT), 32'(m_late));
`endif
        if (ARVALID && ARREADY) begin
            obs_hs++;
            obs_addr.push_back(ARADDR);
        end
        obs_fiforst += int'(FIFORST);
        obs_fifowr  += int'(FIFOWR);
        obs_done    += int'(FRAME_DONE);
        hs   = exp_arvalid && ARREADY;
        acc  = RVALID && m_rready;
        last = acc && RLAST;
        pre_phase = m_phase;
        @(posedge ACLK);
        if (ARST) begin
            m_phase = 0; m_flush_left = 0; m_left = 0; m_inflight = 0;
            m_held = 0; m_done = 0; m_rready = 0; m_addr = '0; m_late = 0;
            q.delete();
        end else begin
            done_n = 0;
            if (VSTART && DISPON && pre_phase != 0 && m_late < 65535) m_late++;
            case (m_phase)
                0: if (VSTART && DISPON) begin
                    m_phase = 1; m_addr = DISPADDR; m_left = FB / BL; m_flush_left = FC;
                end
                1: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_phase = 2;
                end
                2: if (m_left == 0 && m_inflight == 0) begin
                    m_phase = 0; done_n = 1;
                end else if (!DISPON && !m_held) begin
                    m_phase = 3;
                end
                default: if (m_inflight == 0) m_phase = 0;
            endcase
            if (hs) begin
                m_addr = m_addr + BL * 8;
                m_left--;
                q.push_back(BL);
            end
            m_held = exp_arvalid && !ARREADY;
            if (acc) begin
                q[0] = q[0] - 1;
                if (q[0] == 0) void'(q.pop_front());
                r_budget--;
            end
            if (hs) m_inflight++;
            if (last && m_inflight > 0) m_inflight--;
            m_rready = 1;
            m_done = done_n;
        end
        #1;
    endtask

    task automatic do_reset();
        ARST = 1'b1;
        VSTART = 1'b0;
        cycle();
        cycle();
        ARST = 1'b0;
        clear_obs();
    endtask

    task automatic start_frame(input logic [31:0] base);
        DISPADDR = base;
        DISPON = 1'b1;
        VSTART = 1'b1;
        cycle();
        VSTART = 1'b0;
    endtask

    task automatic run_until_idle(input int maxc);
        int k = 0;
        while (m_phase != 0 && k < maxc) begin
            cycle();
            k++;
        end
        cycle();
        chk("idle_reached", 32'(BUSY), 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_fiforst", 32'(FIFORST), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rready", 32'(RREADY), 32'd0);
        chk("rst_araddr", ARADDR, 32'd0);
        chk("rst_arlen", 32'(ARLEN), 32'd15);
        cycle();
        chk("post_rst_rready", 32'(RREADY), 32'd1);

        // Full frame, slave always ready
        clear_obs();
        start_frame(32'h1000_0000);
        run_until_idle(400);
        chk("full_fiforst_cycles", 32'(obs_fiforst), 32'd8);
        chk("full_fifowr", 32'(obs_fifowr), 32'd64);
        chk("full_done", 32'(obs_done), 32'd1);
        chk("full_bursts", 32'(obs_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            chk("full_addr", obs_addr[i], 32'h1000_0000 + 32'(i) * 32'h80);

        // Credit limit
        do_reset();
        r_budget = 0;
        start_frame(32'h2000_0000);
        run(30);
        chk("credit_hs2", 32'(obs_hs), 32'd2);
        chk("credit_arvalid_low", 32'(ARVALID), 32'd0);
        r_budget = 16;
        run(25);
        chk("credit_hs3", 32'(obs_hs), 32'd3);
        r_budget = BIG;
        run_until_idle(400);
        chk("credit_done", 32'(obs_done), 32'd1);

        // Throttle and stability
        do_reset();
        BUF_WREADY = 1'b0;
        start_frame(32'h1000_0000);
        run(20);
        chk("throttle_hs0", 32'(obs_hs), 32'd0);
        chk("throttle_arvalid", 32'(ARVALID), 32'd0);
        ar_pct = 0;
        BUF_WREADY = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            BUF_WREADY = i[0];
            cycle();
            chk("stable_arvalid", 32'(ARVALID), 32'd1);
            chk("stable_araddr", ARADDR, 32'h1000_0000);
        end
        ar_pct = 100;
        BUF_WREADY = 1'b1;
        run_until_idle(400);

        // Abort after two bursts
        do_reset();
        r_budget = 0;
        start_frame(32'h3000_0000);
        for (int i = 0; i < 60 && obs_hs < 2; i++) cycle();
        chk("abort_hs2", 32'(obs_hs), 32'd2);
        DISPON = 1'b0;
        run(5);
        chk("abort_busy", 32'(BUSY), 32'd1);
        r_budget = BIG;
        run_until_idle(200);
        chk("abort_fifowr", 32'(obs_fifowr), 32'd0);
        chk("abort_no_done", 32'(obs_done), 32'd0);
        DISPON = 1'b1;

        // Late VSTART mid-RUN
        do_reset();
        start_frame(32'h1000_0000);
        run(12);
        DISPADDR = 32'h2000_0000;
        VSTART = 1'b1;
        cycle();
        VSTART = 1'b0;
        run_until_idle(400);
        chk("late_bursts", 32'(obs_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            chk("late_addr", obs_addr[i], 32'h1000_0000 + 32'(i) * 32'h80);
        chk("late_done", 32'(obs_done), 32'd1);
`ifdef DISP_FETCH_LATE_EN
        chk("late_cnt_one", 32'(LATE_CNT), 32'd1);
`endif

        // Reset mid-burst
        do_reset();
        ar_pct = 0;
        start_frame(32'h4000_0000);
        run(12);
        chk("midrst_pending", 32'(ARVALID), 32'd1);
        ARST = 1'b1;
        cycle();
        chk("midrst_arvalid", 32'(ARVALID), 32'd0);
        chk("midrst_fiforst", 32'(FIFORST), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        ARST = 1'b0;
        ar_pct = 100;

        // Random traffic
        do_reset();
        ar_pct = 60;
        r_pct = 70;
        for (int i = 0; i < 4000; i++) begin
            ARST       = ($urandom_range(499) == 0);
            DISPON     = ($urandom_range(99) < 92);
            VSTART     = ($urandom_range(19) == 0);
            BUF_WREADY = ($urandom_range(99) < 70);
            DISPADDR   = $urandom() & 32'hFFFF_FF80;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
